// File: rtl/bit_serial_alu_ctrl.sv
// ============================================================================
// Module      : bit_serial_alu_ctrl
// Description : Bit-serial ALU. Pushes one operand bit per cycle, LSB first,
//               through a single 1-bit ALU slice (AND/OR/sum/less) and
//               assembles the result in an internal shift register. The
//               visible result and flags change only on entry to DONE.
// Ports       : clk      - clock, rising-edge active
//               rst_n    - synchronous active-low reset
//               start    - begin an operation (sampled in IDLE only)
//               op[3:0]  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB,
//                          0111 SLT, 1100 NOR, others give 0
//               a, b     - operands, captured when start is accepted
//               busy     - high whenever the FSM is not IDLE
//               done     - one-cycle pulse marking a valid result
//               result   - registered result, held until next operation
//               zero     - registered (result == 0)
//               overflow - registered signed overflow (ADD/SUB/SLT only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_fin;    // all bits processed; next RUN edge publishes
    logic             r_ovf;

    // Slice control word: {ainvert, binvert, slice_op[1:0], arith}
    function automatic logic [4:0] f_decode(input logic [3:0] f_op);
        logic [4:0] v_ctl;
        case (f_op)
            4'b0000: v_ctl = 5'b0_0_00_0;
            4'b0001: v_ctl = 5'b0_0_01_0;
            4'b0010: v_ctl = 5'b0_0_10_1;
            4'b0110: v_ctl = 5'b0_1_10_1;
            4'b0111: v_ctl = 5'b0_1_10_1;
            4'b1100: v_ctl = 5'b1_1_00_0;
            default: v_ctl = 5'b0_0_11_0;
        endcase
        return v_ctl;
    endfunction

    logic [4:0] w_ctl;
    logic       w_ainv;
    logic       w_binv;
    logic [1:0] w_sop;
    logic       w_arith;
    logic       w_is_slt;
    logic       w_start_binv;

    assign w_ctl    = f_decode(r_op);
    assign w_ainv   = w_ctl[4];
    assign w_binv   = w_ctl[3];
    assign w_sop    = w_ctl[2:1];
    assign w_arith  = w_ctl[0];
    assign w_is_slt = (r_op == 4'b0111);

    // Carry preload needs Binvert of the op being accepted, before r_op holds it
    assign w_start_binv = (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1100);

    // ---------------------------------------------------------------- slice
    logic w_abit;
    logic w_bbit;
    logic w_sum;
    logic w_cout;
    logic w_res;
    logic w_is_msb;
    logic w_ovf;
    logic w_less;

    assign w_abit   = r_a[r_cnt] ^ w_ainv;
    assign w_bbit   = r_b[r_cnt] ^ w_binv;
    assign w_sum    = w_abit ^ w_bbit ^ r_carry;
    assign w_cout   = (w_abit & w_bbit) | (w_abit & r_carry) | (w_bbit & r_carry);
    assign w_is_msb = (r_cnt == C_LAST);
    // At the MSB, r_carry is the carry into the MSB
    assign w_ovf    = w_arith & (r_carry ^ w_cout);
    assign w_less   = w_sum ^ w_ovf;

    always_comb begin
        w_res = 1'b0;
        case (w_sop)
            2'b00:   w_res = w_abit & w_bbit;
            2'b01:   w_res = w_abit | w_bbit;
            2'b10:   w_res = w_sum;
            default: w_res = 1'b0;   // Less input tied low
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_fin) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 4'b0000;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_fin    <= 1'b0;
            r_ovf    <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_carry <= w_start_binv;
                        r_fin   <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!r_fin) begin
                        r_carry <= w_cout;
                        if (w_is_msb) begin
                            // Counter parks at the last bit; no wrap
                            r_fin <= 1'b1;
                            r_ovf <= w_ovf;
                            if (w_is_slt) begin
                                r_shift <= {{(WIDTH-1){1'b0}}, w_less};
                            end else begin
                                r_shift <= {w_res, r_shift[WIDTH-1:1]};
                            end
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_shift <= {w_res, r_shift[WIDTH-1:1]};
                        end
                    end else begin
                        // DONE entry edge: publish result and flags together
                        result   <= r_shift;
                        zero     <= (r_shift == '0);
                        overflow <= r_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
// ============================================================================
// Module      : tb_bit_serial_alu_ctrl
// Description : Scoreboard bench for bit_serial_alu_ctrl (WIDTH=32). The
//               stimulus process queues expected results from an arithmetic
//               reference model; a monitor pops and compares on every done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_alu_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        v;
        int unsigned due;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain two's-complement arithmetic on whole words
    function automatic exp_t model(input logic [3:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
        exp_t        e;
        logic [31:0] d;
        e.res = 32'd0;
        e.v   = 1'b0;
        e.due = 0;
        case (f_op)
            4'b0000: e.res = fa & fb;
            4'b0001: e.res = fa | fb;
            4'b0010: begin
                e.res = fa + fb;
                e.v   = (fa[31] == fb[31]) && (e.res[31] != fa[31]);
            end
            4'b0110: begin
                e.res = fa - fb;
                e.v   = (fa[31] != fb[31]) && (e.res[31] != fa[31]);
            end
            4'b0111: begin
                d     = fa - fb;
                e.v   = (fa[31] != fb[31]) && (d[31] != fa[31]);
                e.res = ($signed(fa) < $signed(fb)) ? 32'd1 : 32'd0;
            end
            4'b1100: e.res = ~(fa | fb);
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result",   {32'd0, result},   {32'd0, e.res});
                chk("zero",     {63'd0, zero},     {63'd0, e.z});
                chk("overflow", {63'd0, overflow}, {63'd0, e.v});
                chk("done_time", 64'(cyc), 64'(e.due));
            end
        end
        prev_done <= done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: got busy=%b, expected 0 within 200 cycles", busy);
        end
    endtask

    // Issue at a negedge; start is sampled at the following posedge (E0).
    // done is expected in the cycle after edge E0+WIDTH+1.
    task automatic issue(input logic [3:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                         input bit expect_it);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = i_op;
        a     = i_a;
        b     = i_b;
        if (expect_it) begin
            e     = model(i_op, i_a, i_b);
            e.due = cyc + 1 + WIDTH + 1;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom);
        a     = $urandom;
        b     = $urandom;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops_tbl [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    initial begin
        rst_n = 1'b0;
        start = 1'b1;   // start held high during reset must be ignored
        op    = 4'b0010;
        a     = 32'd1;
        b     = 32'd1;
        repeat (3) @(negedge clk);
        chk("reset_busy",     {63'd0, busy},     64'd0);
        chk("reset_done",     {63'd0, done},     64'd0);
        chk("reset_result",   {32'd0, result},   64'd0);
        chk("reset_zero",     {63'd0, zero},     64'd1);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        chk("result_stable_in_run", {32'd0, result}, 64'd0);
        issue(4'b0110, 32'd5, 32'd5, 1);
        issue(4'b0110, 32'h8000_0000, 32'd1, 1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1);
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1);
        issue(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 1);
        issue(4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 1);
        issue(4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 1);
        issue(4'b1111, 32'h0F0F_0F0F, 32'h00FF_00FF, 1);

        // Start pulsed mid-RUN is ignored; the next one in IDLE is taken
        issue(4'b0010, 32'd2, 32'd3, 1);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        issue(4'b0010, 32'd1, 32'd1, 1);

        // Start pulsed during the DONE cycle is ignored
        begin
            int n = 0;
            while (done !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("done_seen", {63'd0, done}, 64'd1);
            start = 1'b1; op = 4'b0010; a = 32'd9; b = 32'd9;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
        end

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [3:0] r_op;
            if ($urandom_range(0, 6) == 0) r_op = 4'($urandom);
            else                           r_op = ops_tbl[$urandom_range(0, 5)];
            issue(r_op, pick(), pick(), 1);
        end

        // Reset during bit 10 of an operation: aborted, no done
        wait_idle();
        chk("pre_reset_result_nonzero", {63'd0, (result != 32'd0)}, 64'd1);
        issue(4'b0010, 32'h1234_5678, 32'h1111_1111, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy",   {63'd0, busy},   64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_zero",   {63'd0, zero},   64'd1);
        chk("abort_done",   {63'd0, done},   64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_activity", {63'd0, busy}, 64'd0);

        // A fresh operation after the abort
        issue(4'b0110, 32'd100, 32'd58, 1);

        begin
            int n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("scoreboard_drained", 64'(q.size()), 64'd0);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
